serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor that computes DIFF = A − B over WIDTH clock cycles, one half/full-subtractor stage per cycle plus a borrow flip-flop.
- It is the inverse-direction counterpart to the adder blocks in the arithmetic library.
- Used where area matters more than latency; a start/busy/done handshake lets a controller launch an operation and collect the result.

Parameters:
- WIDTH, 8: operand and result width in bits, minimum 2.
- CNT_W, $clog2(WIDTH+1): width of the internal bit counter (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start
- b  input  WIDTH  subtrahend; captured on the accepted start
- busy  output  1  high while in SHIFT
- done  output  1  single-cycle pulse when the result is valid
- diff  output  WIDTH  difference, a − b modulo 2^WIDTH
- borrow  output  1  final borrow-out; 1 when a < b (unsigned)

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, regardless of state:
  - state=IDLE
  - busy=0, done=0, diff=0, borrow=0
  - internal shift registers, borrow flop and counter cleared
- Reset mid-operation aborts the operation: no done pulse, outputs cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: capture a→sa and b→sb, clear the borrow flop, set cnt=0, go to SHIFT.
  - Otherwise stay in IDLE.
  - diff and borrow hold their last result.
- SHIFT (busy=1), each cycle:
  - Stage inputs are a0=sa[0], b0=sb[0], bi=borrow flop.
  - d = a0 ^ b0 ^ bi.
  - bo = (~a0 & b0) | (~(a0 ^ b0) & bi).
  - Shift d into the result register at the MSB, right-shifting the existing contents.
  - Right-shift sa and sb; borrow flop <= bo; cnt <= cnt+1.
  - When cnt == WIDTH−1 (the last bit processed), go to DONE.
- DONE:
  - done=1 for exactly this one cycle, busy=0.
  - diff = result register; borrow = borrow flop.
  - Next state is IDLE unconditionally.
- Latency: start accepted at edge N → busy high N+1..N+WIDTH → done high in cycle N+WIDTH+1. For WIDTH=8, done is high 9 cycles after start is sampled.
- diff and borrow are registered, update only on entry to DONE, and remain stable until the next DONE or reset.
- start while busy=1 or done=1 is ignored; no queuing.
- start held high continuously: a new operation launches on the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.
- a and b may change freely after the accepted start without affecting the result.
- No X-propagation from unused state encodings: any illegal state returns to IDLE.

Test Plan:
- After rst held 2 cycles → busy=0, done=0, diff=0x00, borrow=0. Then a=0x05, b=0x03, start pulse → done exactly 9 cycles later, diff=0x02, borrow=0.
- a=0x03, b=0x05 → diff=0xFE, borrow=1. Also a=0x00, b=0x01 → diff=0xFF, borrow=1.
- Boundary cases:
  - a=0xFF, b=0x01 → diff=0xFE, borrow=0.
  - a=0x00, b=0x00 → diff=0x00, borrow=0.
  - a=0xAA, b=0xAA → diff=0x00, borrow=0.
- Launch a=0x10, b=0x01. Mid-operation, assert start with a=0x77, b=0x11 at cycle 3 and change a/b → result still diff=0x0F, borrow=0. Only one done pulse.
- start held high, first pair a=0x20, b=0x08, then a=0x08, b=0x20 → done pulses 10 cycles apart: diff=0x18/borrow=0, then diff=0xE8/borrow=1.
- Launch a=0x55, b=0x22, assert rst at cycle 4 of SHIFT → next cycle busy=0, diff=0x00, borrow=0, and no done pulse ever. A subsequent start with a=0x09, b=0x04 yields diff=0x05.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first subtractor: diff = a - b (mod 2^WIDTH) computed one
//   bit per clock through a single full-subtractor stage and a borrow flop.
//   A start/busy/done handshake lets a controller launch an operation and
//   collect the registered result.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   start  : launch request, only honoured while idle
//   a, b   : minuend / subtrahend, captured on the accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when diff/borrow hold a fresh result
//   diff   : registered difference, a - b modulo 2^WIDTH
//   borrow : registered final borrow-out, 1 when a < b (unsigned)
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Bit counter width, derived from WIDTH.
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bf_q, bf_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Single full-subtractor stage.
  logic a0, b0, bi, d, bo, last_bit;

  always_comb begin
    a0       = sa_q[0];
    b0       = sb_q[0];
    bi       = bf_q;
    d        = a0 ^ b0 ^ bi;
    bo       = (~a0 & b0) | (~(a0 ^ b0) & bi);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    bf_d     = bf_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          res_d   = '0;
          bf_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        res_d = {d, res_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bf_d  = bo;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Publish on the same edge the last bit is produced, so the
          // outputs already hold the full result while DONE is asserted.
          diff_d   = {d, res_q[WIDTH-1:1]};
          borrow_d = bo;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      bf_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      bf_q     <= bf_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
  } exp_t;

  exp_t sb_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular subtraction and unsigned compare.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.diff   = x - y;
    e.borrow = (x < y);
    return e;
  endfunction

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    sb_q.push_back(model(x, y));
  endtask

  // Drive one start pulse; returns right after the accepting edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency and pop/compare.
  // 'elapsed' = ticks since the accepting edge. The result registers on the
  // edge WIDTH after acceptance, so the edge WIDTH+1 after it samples done=1.
  task automatic wait_result(input string tag, input int elapsed);
    int k;
    exp_t e;
    k = elapsed;
    while (done !== 1'b1 && k < int'(W) + 4) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, W);
    chk({tag, "_busy_low"}, busy, 1'b0);
    if (sb_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_diff"}, diff, e.diff);
      chk({tag, "_borrow"}, borrow, e.borrow);
    end
  endtask

  logic [W-1:0] ta [6];
  logic [W-1:0] tb [6];
  int snap;
  int k2;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_borrow", borrow, 1'b0);
    rst = 1'b0;
    tick();

    // Basic and boundary pairs.
    ta = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h00, 8'hAA};
    tb = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h00, 8'hAA};
    for (int i = 0; i < 6; i++) begin
      push(ta[i], tb[i]);
      launch(ta[i], tb[i]);
      chk("busy_after_accept", busy, 1'b1);
      wait_result($sformatf("pair%0d", i), 0);
      tick();
    end

    // Spec constants cross-check on a known pair.
    push(8'h05, 8'h03);
    launch(8'h05, 8'h03);
    wait_result("const", 0);
    chk("const_diff_lit", diff, 8'h02);
    tick();

    // Start during busy is ignored; a/b changes after capture are harmless.
    snap = done_cnt;
    push(8'h10, 8'h01);
    launch(8'h10, 8'h01);
    tick();
    tick();
    a     = 8'h77;
    b     = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'h33;
    b     = 8'h44;
    wait_result("midstart", 3);
    chk("midstart_diff_lit", diff, 8'h0F);
    for (int i = 0; i < 2 * int'(W); i++) tick();
    chk("midstart_one_done", done_cnt - snap, 1);

    // Start held high: back-to-back launches every WIDTH+2 cycles.
    push(8'h20, 8'h08);
    push(8'h08, 8'h20);
    a     = 8'h20;
    b     = 8'h08;
    start = 1'b1;
    tick();
    a     = 8'h08;
    b     = 8'h20;
    wait_result("hold1", 0);
    k2 = 0;
    do begin
      tick();
      k2++;
    end while (done !== 1'b1 && k2 < 20);
    start = 1'b0;
    chk("hold_spacing", k2, W + 2);
    if (sb_q.size() == 0) begin
      chk("hold2_queue_empty", 1, 0);
    end else begin
      exp_t e;
      e = sb_q.pop_front();
      chk("hold2_diff", diff, e.diff);
      chk("hold2_borrow", borrow, e.borrow);
    end
    tick();
    tick();
    chk("hold_stops", busy, 1'b0);

    // Reset mid-operation aborts without a done pulse.
    launch(8'h55, 8'h22);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    snap = done_cnt;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_diff", diff, 8'h00);
    chk("abort_borrow", borrow, 1'b0);
    for (int i = 0; i < 2 * int'(W); i++) tick();
    chk("abort_no_done", done_cnt - snap, 0);
    push(8'h09, 8'h04);
    launch(8'h09, 8'h04);
    wait_result("after_abort", 0);
    tick();

    // A few random operands.
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      push(x, y);
      launch(x, y);
      wait_result($sformatf("rand%0d", i), 0);
      tick();
    end

    chk("queue_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
